tabela_precos: RTL and testbench

TABELA_PRECOS -- requirements
Module: tabela_precos

---
 rtl/tabela_precos_pkg.sv | 9 +
 rtl/satura_preco.sv | 18 +
 rtl/tabela_precos.sv | 123 ++++++++++++
 tb/tb_tabela_precos.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tabela_precos_pkg.sv
// Shared constants for the price table: default widths, saturation ceiling
// and the reserved "no product" code.
package tabela_precos_pkg;

  localparam int unsigned PRECO_W_DEF   = 9;
  localparam int unsigned PRECO_MAX_DEF = 500;
  localparam int unsigned PROD_NENHUM   = 0;

endpackage

// File: rtl/satura_preco.sv
// Combinational price clip: values above PRECO_MAX are clamped to it and flagged.
module satura_preco
  import tabela_precos_pkg::*;
#(
  parameter int unsigned PRECO_W   = PRECO_W_DEF,
  parameter int unsigned PRECO_MAX = PRECO_MAX_DEF
) (
  input  logic [PRECO_W-1:0] raw,
  output logic [PRECO_W-1:0] clipped,
  output logic               sat
);

  localparam logic [PRECO_W-1:0] TETO = PRECO_W'(PRECO_MAX);

  assign sat     = raw > TETO;
  assign clipped = sat ? TETO : raw;

endmodule

// File: rtl/tabela_precos.sv
// Programmable product price table: saturating writes, one-cycle registered
// lookups with write-first forwarding.
module tabela_precos
  import tabela_precos_pkg::*;
#(
  parameter int unsigned N_PROD    = 3,
  parameter int unsigned PRECO_W   = PRECO_W_DEF,
  parameter int unsigned PRECO_MAX = PRECO_MAX_DEF,
  localparam int unsigned ADDR_W   = $clog2(N_PROD + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_prod,
  input  logic [PRECO_W-1:0] wr_preco,
  output logic               wr_sat,
  output logic               wr_err,
  input  logic               req,
  input  logic [ADDR_W-1:0]  prod,
  output logic               valid,
  output logic [PRECO_W-1:0] preco_fil,
  output logic               prod_err
);

  if (N_PROD < 1 || N_PROD > 15) begin : g_bad_n_prod
    $error("tabela_precos: N_PROD must be in 1..15");
  end
  if ((PRECO_MAX >> PRECO_W) != 0) begin : g_bad_preco_max
    $error("tabela_precos: PRECO_MAX does not fit in PRECO_W bits");
  end

  logic [PRECO_W-1:0] clipped;
  logic               sat;

  satura_preco #(
    .PRECO_W   (PRECO_W),
    .PRECO_MAX (PRECO_MAX)
  ) u_satura (
    .raw     (wr_preco),
    .clipped (clipped),
    .sat     (sat)
  );

  // Entry i holds product code i+1; code 0 has no storage.
  logic [PRECO_W-1:0] tab_q [N_PROD];
  logic [N_PROD-1:0]  wr_hit;
  logic [N_PROD-1:0]  rd_hit;
  logic               wr_ok;
  logic               fwd;
  logic [PRECO_W-1:0] rd_val;

  always_comb begin
    wr_hit = '0;
    rd_hit = '0;
    for (int unsigned i = 0; i < N_PROD; i++) begin
      wr_hit[i] = (wr_prod == ADDR_W'(i + 1));
      rd_hit[i] = (prod == ADDR_W'(i + 1));
    end
  end

  assign wr_ok = wr_en & (|wr_hit);
  assign fwd   = wr_ok & (wr_prod == prod);

  always_comb begin
    rd_val = '0;
    for (int unsigned i = 0; i < N_PROD; i++) begin
      if (rd_hit[i]) rd_val = tab_q[i];
    end
    // Same-cycle write to the looked-up code wins over the stored value.
    if (fwd) rd_val = clipped;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_PROD; i++) tab_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_PROD; i++) begin
        if (wr_ok && wr_hit[i]) tab_q[i] <= clipped;
      end
    end
  end

  logic               valid_q, valid_d;
  logic [PRECO_W-1:0] fil_q, fil_d;
  logic               perr_q, perr_d;
  logic               sat_q, sat_d;
  logic               err_q, err_d;

  always_comb begin
    valid_d = req;
    fil_d   = fil_q;
    perr_d  = perr_q;
    if (req) begin
      fil_d  = rd_val;
      perr_d = (prod != ADDR_W'(PROD_NENHUM)) && !(|rd_hit);
    end
    sat_d = wr_ok & sat;
    err_d = wr_en & ~wr_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      fil_q   <= '0;
      perr_q  <= 1'b0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      fil_q   <= fil_d;
      perr_q  <= perr_d;
      sat_q   <= sat_d;
      err_q   <= err_d;
    end
  end

  assign valid     = valid_q;
  assign preco_fil = fil_q;
  assign prod_err  = perr_q;
  assign wr_sat    = sat_q;
  assign wr_err    = err_q;

endmodule

// File: tb/tb_tabela_precos.sv
// Bench for tabela_precos: default instance (3 products) and a 4-product
// instance that can see illegal codes, both against a behavioural model.
module tb_tabela_precos;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [2:0] wr_prod;
  logic [8:0] wr_preco;
  logic       req;
  logic [2:0] prod;

  logic       v3, pe3, s3, e3;
  logic [8:0] f3;
  logic       v4, pe4, s4, e4;
  logic [8:0] f4;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 0;

  tabela_precos u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_prod   (wr_prod[1:0]),
    .wr_preco  (wr_preco),
    .wr_sat    (s3),
    .wr_err    (e3),
    .req       (req),
    .prod      (prod[1:0]),
    .valid     (v3),
    .preco_fil (f3),
    .prod_err  (pe3)
  );

  tabela_precos #(
    .N_PROD (4)
  ) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_prod   (wr_prod),
    .wr_preco  (wr_preco),
    .wr_sat    (s4),
    .wr_err    (e4),
    .req       (req),
    .prod      (prod),
    .valid     (v4),
    .preco_fil (f4),
    .prod_err  (pe4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: index 0 = 3-product instance, 1 = 4-product instance.
  int unsigned m_tab [2][16];
  int unsigned m_fil [2];
  bit          m_valid [2];
  bit          m_perr [2];
  bit          m_sat [2];
  bit          m_err [2];

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 16; c++) m_tab[k][c] = 0;
      m_fil[k] = 0; m_valid[k] = 0; m_perr[k] = 0; m_sat[k] = 0; m_err[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int unsigned n, wp, p, nv;
      bit legal;
      n     = (k == 0) ? 3 : 4;
      wp    = (k == 0) ? int'(wr_prod[1:0]) : int'(wr_prod);
      p     = (k == 0) ? int'(prod[1:0]) : int'(prod);
      legal = wr_en && wp >= 1 && wp <= n;
      nv    = (wr_preco > 500) ? 500 : int'(wr_preco);
      m_sat[k] = legal && (wr_preco > 500);
      m_err[k] = wr_en && !legal;
      if (legal) m_tab[k][wp] = nv;
      m_valid[k] = req;
      if (req) begin
        if (p == 0) begin
          m_fil[k] = 0; m_perr[k] = 0;
        end else if (p > n) begin
          m_fil[k] = 0; m_perr[k] = 1;
        end else begin
          m_fil[k] = m_tab[k][p]; m_perr[k] = 0;
        end
      end
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_clear();
      else model_step();
    end
  end

  task automatic chk(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic compare_inst(input int k, input logic v, input logic [8:0] f,
                              input logic pe, input logic s, input logic e);
    chk($sformatf("valid[%0d]", k), int'(v), int'(m_valid[k]));
    chk($sformatf("preco_fil[%0d]", k), int'(f), int'(m_fil[k]));
    chk($sformatf("wr_sat[%0d]", k), int'(s), int'(m_sat[k]));
    chk($sformatf("wr_err[%0d]", k), int'(e), int'(m_err[k]));
    if (m_valid[k]) chk($sformatf("prod_err[%0d]", k), int'(pe), int'(m_perr[k]));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        compare_inst(0, v3, f3, pe3, s3, e3);
        compare_inst(1, v4, f4, pe4, s4, e4);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b1; wr_en = 1'b0; wr_prod = '0; wr_preco = '0; req = 1'b0; prod = '0;
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    chk("reset_fil", int'(f3), 0);
    chk("reset_valid", int'(v3), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Unprogrammed table reads zero.
    req = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      prod = 3'(c);
      step();
      chk($sformatf("init_valid_%0d", c), int'(v3), 1);
      chk($sformatf("init_fil_%0d", c), int'(f3), 0);
      chk($sformatf("init_perr_%0d", c), int'(pe3), 0);
    end
    req = 1'b0;

    wr_en = 1'b1;
    wr_prod = 3'd1; wr_preco = 9'd250; step();
    chk("sat_250", int'(s3), 0);
    wr_prod = 3'd2; wr_preco = 9'd500; step();
    chk("sat_500", int'(s3), 0);
    wr_prod = 3'd3; wr_preco = 9'd501; step();
    chk("sat_501", int'(s3), 1);
    chk("err_501", int'(e3), 0);
    wr_en = 1'b0;

    req = 1'b1;
    prod = 3'd1; step(); chk("look_1", int'(f3), 250);
    prod = 3'd2; step(); chk("look_2", int'(f3), 500);
    prod = 3'd3; step(); chk("look_3", int'(f3), 500);
    req = 1'b0;

    wr_en = 1'b1; wr_prod = 3'd0; wr_preco = 9'd77; step();
    chk("err_code0_3", int'(e3), 1);
    chk("err_code0_4", int'(e4), 1);
    // Code 5 is illegal for the 4-product table; the 3-product one sees code 1.
    wr_prod = 3'd5; wr_preco = 9'd250; step();
    chk("err_code5_4", int'(e4), 1);
    chk("err_code5_3", int'(e3), 0);
    wr_en = 1'b0;

    req = 1'b1;
    prod = 3'd5; step();
    chk("illegal_valid", int'(v4), 1);
    chk("illegal_fil", int'(f4), 0);
    chk("illegal_perr", int'(pe4), 1);
    prod = 3'd1; step();
    chk("after_illegal_fil", int'(f4), 250);
    chk("after_illegal_perr", int'(pe4), 0);
    req = 1'b0; step();
    chk("idle_valid", int'(v4), 0);
    chk("idle_hold", int'(f4), 250);

    wr_en = 1'b1; wr_prod = 3'd2; wr_preco = 9'd120; req = 1'b1; prod = 3'd2; step();
    chk("fwd_fil_3", int'(f3), 120);
    chk("fwd_fil_4", int'(f4), 120);
    wr_preco = 9'd500; req = 1'b0; step();
    wr_en = 1'b0;

    req = 1'b1;
    prod = 3'd1; step(); chk("b2b_1", int'(f3), 250); chk("b2b_v1", int'(v3), 1);
    prod = 3'd0; step(); chk("b2b_0", int'(f3), 0);   chk("b2b_v0", int'(v3), 1);
    prod = 3'd2; step(); chk("b2b_2", int'(f3), 500); chk("b2b_v2", int'(v3), 1);
    prod = 3'd3; step(); chk("b2b_3", int'(f3), 500); chk("b2b_v3", int'(v3), 1);

    // Reset lands while a write and a lookup are pending.
    prod = 3'd1; wr_en = 1'b1; wr_prod = 3'd4; wr_preco = 9'd9;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_fil", int'(f3), 0);
    chk("midrst_valid", int'(v3), 0);
    req = 1'b0; wr_en = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("postrst_valid", int'(v4), 0);
    chk("postrst_err", int'(e4), 0);
    req = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      prod = 3'(c);
      step();
      chk($sformatf("postrst_fil_%0d", c), int'(f4), 0);
    end
    req = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_prod = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: wr_preco = 9'd500;
        1: wr_preco = 9'd501;
        2: wr_preco = 9'd499;
        default: wr_preco = 9'($urandom_range(0, 511));
      endcase
      req  = ($urandom_range(0, 3) != 0);
      prod = 3'($urandom_range(0, 7));
      if (i == 1500) begin
        #1 rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
      step();
    end
    wr_en = 1'b0; req = 1'b0;
    step();
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
